instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
- Pipeline stage directly upstream of the instruction decoder.
- Owns the PC and drives the instruction-memory request.
- Holds the IF/ID pipeline register (IR, PC+1, valid) that feeds the decoder.
- Handles stall from the hazard unit and redirect from branch/jump resolution; inserts all-zero IR (opcode 000_0000 = NOP) as bubble.

Parameters:
- PC_W, 32, PC / instruction address width; word-addressed, PC advances by 1.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- stall  input  1  hold IF/ID register and PC (hazard unit).
- redirect  input  1  branch/jump taken, from execute stage.
- redirect_pc  input  PC_W  target PC when redirect=1.
- imem_req  output  1  instruction-memory request valid.
- imem_addr  output  PC_W  instruction-memory word address.
- imem_rdata  input  32  instruction word, valid only when imem_ready=1.
- imem_ready  input  1  memory returns imem_rdata for current imem_addr this cycle.
- IR  output  32  IF/ID instruction register, to decoder.
- PC_1  output  PC_W  IF/ID register: fetch PC + 1 (branch base).
- valid  output  1  IF/ID entry holds a real instruction.

Behaviour:
- Reset (async, immediate): pc=RESET_PC, state=REQ, skid buffer empty, IR=0, PC_1=0, valid=0, imem_req=0 while rst=1.
- Memory handshake:
  - imem_req=1 with imem_addr=pc in state REQ.
  - Access completes in any cycle with imem_req & imem_ready (0 or more wait cycles).
  - imem_addr stays stable until completion, except on redirect, which abandons the access.
- State REQ:
  - ready & !stall & !redirect: IR<=rdata, PC_1<=pc+1, valid<=1, pc<=pc+1, stay REQ. Gives 1 instr/cycle with zero-wait memory.
  - ready & stall & !redirect: capture rdata and pc+1 into the skid buffer, pc<=pc+1, go BUF. IF/ID held.
  - !ready & !stall & !redirect: IR<=0, valid<=0, PC_1 held (bubble).
  - !ready & stall: IF/ID held, pc held.
- State BUF:
  - imem_req=0.
  - While stall: hold everything.
  - On !stall: IF/ID<=buffer (valid=1), buffer cleared, go REQ.
- Redirect (highest priority, any state, even with stall=1):
  - pc<=redirect_pc; IR<=0, valid<=0; skid buffer discarded; go REQ.
  - Any outstanding or same-cycle completed fetch is dropped.
  - Next cycle: imem_addr=redirect_pc.
- Stall with valid IF/ID: IR, PC_1, valid unchanged bit-for-bit.
- PC arithmetic modulo 2^PC_W; pc=all-ones wraps to 0, PC_1 wraps likewise.
- Combinational paths:
  - imem_req/imem_addr depend only on state/pc (registered).
  - No combinational path from imem_rdata to IR output; IR is registered only.
- Latency: instruction at address A appears on IR one clock after its ready cycle.

Test Plan:
1. Reset with RESET_PC=0x10, zero-wait memory returning addr+0x100 -> imem_addr 0x10,0x11,0x12 on successive cycles; IR=0x110,0x111,0x112; PC_1=0x11,0x12,0x13; valid=1 from first edge after reset release.
2. Memory with 2 wait cycles on address 0x4 -> imem_addr held 0x4 for 3 cycles; IR=0, valid=0 for 2 cycles; then IR=rdata(0x4), PC_1=0x5.
3. stall=1 for 3 cycles while ready=1 on address 0x8 -> IF/ID unchanged, imem_req drops after capture. On stall release, IR=rdata(0x8) with PC_1=0x9, then fetch resumes at 0x9; no instruction lost or duplicated.
4. redirect=1, redirect_pc=0x40 during waited fetch of 0x7 -> next cycle IR=0, valid=0, imem_addr=0x40; late ready for 0x7 never reaches IR.
5. redirect and stall both high with a full skid buffer -> buffer discarded, IR=0, valid=0, fetch restarts at redirect_pc.
6. PC_W=4, pc=0xF, zero-wait -> PC_1=0x0, next imem_addr=0x0. Assert rst mid-wait -> outputs clear immediately without a clock edge.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues instruction-memory requests and holds the IF/ID register.
// A one-entry skid buffer keeps a word that returns while the decoder is stalled.
module instruction_fetch #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ready,
  output logic [31:0]     IR,
  output logic [PC_W-1:0] PC_1,
  output logic            valid
);

  typedef enum logic {
    S_REQ = 1'b0,
    S_BUF = 1'b1
  } state_e;

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     buf_ir_q, buf_ir_d;
  logic [PC_W-1:0] buf_pc1_q, buf_pc1_d;
  logic [31:0]     ir_q, ir_d;
  logic [PC_W-1:0] pc1_q, pc1_d;
  logic            valid_q, valid_d;
  logic [PC_W-1:0] pc_inc;

  assign pc_inc = pc_q + PC_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      buf_ir_q  <= '0;
      buf_pc1_q <= '0;
      ir_q      <= '0;
      pc1_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      buf_ir_q  <= buf_ir_d;
      buf_pc1_q <= buf_pc1_d;
      ir_q      <= ir_d;
      pc1_q     <= pc1_d;
      valid_q   <= valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    buf_ir_d  = buf_ir_q;
    buf_pc1_d = buf_pc1_q;
    ir_d      = ir_q;
    pc1_d     = pc1_q;
    valid_d   = valid_q;

    // Redirect overrides everything, including a completion in the same cycle.
    if (redirect) begin
      state_d   = S_REQ;
      pc_d      = redirect_pc;
      buf_ir_d  = '0;
      buf_pc1_d = '0;
      ir_d      = '0;
      valid_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (imem_ready) begin
            pc_d = pc_inc;
            if (stall) begin
              buf_ir_d  = imem_rdata;
              buf_pc1_d = pc_inc;
              state_d   = S_BUF;
            end else begin
              ir_d    = imem_rdata;
              pc1_d   = pc_inc;
              valid_d = 1'b1;
            end
          end else if (!stall) begin
            ir_d    = '0;
            valid_d = 1'b0;
          end
        end
        S_BUF: begin
          if (!stall) begin
            ir_d      = buf_ir_q;
            pc1_d     = buf_pc1_q;
            valid_d   = 1'b1;
            buf_ir_d  = '0;
            buf_pc1_d = '0;
            state_d   = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  // Gate with rst so no request is seen while reset is asserted.
  assign imem_req  = (state_q == S_REQ) && !rst;
  assign imem_addr = pc_q;
  assign IR        = ir_q;
  assign PC_1      = pc1_q;
  assign valid     = valid_q;

endmodule
